// File: rtl/uart_verici_param_pkg.sv
// ============================================================================
// Module   : uart_paket
// Purpose  : Shared FSM encodings, frame code constants and default FIFO depth
//            for the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_paket;

  typedef logic [2:0] durum_t;

  localparam durum_t c_BOSTA  = 3'd0;
  localparam durum_t c_BASLA  = 3'd1;
  localparam durum_t c_VERI   = 3'd2;
  localparam durum_t c_PARITE = 3'd3;
  localparam durum_t c_DUR    = 3'd4;

  localparam logic [1:0] c_VERI_BIT_5   = 2'd0;
  localparam logic [1:0] c_VERI_BIT_6   = 2'd1;
  localparam logic [1:0] c_VERI_BIT_7   = 2'd2;
  localparam logic [1:0] c_VERI_BIT_MAX = 2'd3;

  localparam logic [1:0] c_PARITE_YOK  = 2'd0;
  localparam logic [1:0] c_PARITE_CIFT = 2'd1;
  localparam logic [1:0] c_PARITE_TEK  = 2'd2;
  localparam logic [1:0] c_PARITE_YOK3 = 2'd3;

  localparam int c_FIFO_DERINLIK = 16;

  // Index of the last data bit of a frame for a given width code.
  function automatic logic [3:0] veri_son_bit(input logic [1:0] kod, input int vmax);
    logic [3:0] sonuc;
    case (kod)
      c_VERI_BIT_5: sonuc = 4'd4;
      c_VERI_BIT_6: sonuc = 4'd5;
      c_VERI_BIT_7: sonuc = 4'd6;
      default:      sonuc = 4'(vmax - 1);
    endcase
    return sonuc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_verici_param_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : First-word-fall-through FIFO with occupancy and overflow pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_paket::*;
#(
  parameter int DERINLIK = c_FIFO_DERINLIK,
  parameter int GENISLIK = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          i_yaz,
  input  logic [GENISLIK-1:0]           i_veri,
  input  logic                          i_oku,
  output logic [GENISLIK-1:0]           o_veri,
  output logic                          o_bos,
  output logic                          o_dolu,
  output logic [$clog2(DERINLIK):0]     o_doluluk,
  output logic                          o_tasma
);

  localparam int c_AW = $clog2(DERINLIK);
  localparam logic [c_AW:0] c_DOLU = DERINLIK[c_AW:0];

  logic [GENISLIK-1:0] r_bellek [DERINLIK];
  logic [c_AW-1:0]     r_yaz_ptr;
  logic [c_AW-1:0]     r_oku_ptr;
  logic [c_AW:0]       r_sayi;
  logic                r_tasma;
  logic                w_oku_ok;
  logic                w_yaz_ok;

  assign o_bos     = (r_sayi == '0);
  assign o_dolu    = (r_sayi == c_DOLU);
  assign o_doluluk = r_sayi;
  assign o_tasma   = r_tasma;
  assign o_veri    = r_bellek[r_oku_ptr];

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign w_oku_ok = i_oku && !o_bos;
  assign w_yaz_ok = i_yaz && (!o_dolu || w_oku_ok);

  always_ff @(posedge clk_i) begin
    if (w_yaz_ok) begin
      r_bellek[r_yaz_ptr] <= i_veri;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_yaz_ptr <= '0;
      r_oku_ptr <= '0;
      r_sayi    <= '0;
      r_tasma   <= 1'b0;
    end else begin
      r_tasma <= i_yaz && !w_yaz_ok;
      if (w_yaz_ok) begin
        r_yaz_ptr <= r_yaz_ptr + 1'b1;
      end
      if (w_oku_ok) begin
        r_oku_ptr <= r_oku_ptr + 1'b1;
      end
      case ({w_yaz_ok, w_oku_ok})
        2'b10:   r_sayi <= r_sayi + 1'b1;
        2'b01:   r_sayi <= r_sayi - 1'b1;
        default: r_sayi <= r_sayi;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_verici_param.sv
// ============================================================================
// Module   : uart_verici_param
// Purpose  : Parameterised UART transmitter with TX FIFO, runtime frame format.
//            Parity support is built only when UART_VERICI_PARITE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_verici_param
  import uart_paket::*;
#(
  parameter int FIFO_DERINLIK = c_FIFO_DERINLIK,
  parameter int VERI_MAX      = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [15:0]                      baud_bolen_i,
  input  logic [1:0]                       veri_bit_i,
  input  logic [1:0]                       parite_i,
  input  logic                             dur_bit_i,
  input  logic                             tx_en_i,
  input  logic                             tx_yaz_en_i,
  input  logic [VERI_MAX-1:0]              tx_veri_i,
  output logic                             tx_veri_o,
  output logic                             tx_fifo_bos_o,
  output logic                             tx_fifo_dolu_o,
  output logic [$clog2(FIFO_DERINLIK):0]   tx_doluluk_o,
  output logic                             tx_mesgul_o,
  output logic                             tx_tasma_o
);

  logic [VERI_MAX-1:0] w_fifo_veri;
  logic                w_fifo_bos;
  logic                w_yukle;

  uart_tx_fifo #(
    .DERINLIK (FIFO_DERINLIK),
    .GENISLIK (VERI_MAX)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_yaz     (tx_yaz_en_i),
    .i_veri    (tx_veri_i),
    .i_oku     (w_yukle),
    .o_veri    (w_fifo_veri),
    .o_bos     (w_fifo_bos),
    .o_dolu    (tx_fifo_dolu_o),
    .o_doluluk (tx_doluluk_o),
    .o_tasma   (tx_tasma_o)
  );

  assign tx_fifo_bos_o = w_fifo_bos;

  durum_t              r_durum;
  durum_t              w_sonraki;
  logic [15:0]         r_baud_lim;
  logic [15:0]         r_baud_sayac;
  logic [3:0]          r_bit_sayac;
  logic [3:0]          r_veri_son;
  logic                r_dur_bit;
  logic                r_dur_sayac;
  logic [VERI_MAX-1:0] r_kaydirma;
  logic [VERI_MAX-1:0] w_kaydirma_sonraki;
  logic                r_tx;
  logic                r_mesgul;
  logic                w_tx_sonraki;
  logic                w_mesgul_sonraki;
  logic                w_bit_sonu;
  logic                w_son_veri;
  logic                w_son_dur;
  logic                w_hazir;
  logic                w_parite_var;
  logic                w_parite_cikis;

  assign w_bit_sonu = (r_baud_sayac == r_baud_lim);
  assign w_son_veri = w_bit_sonu && (r_bit_sayac == r_veri_son);
  assign w_son_dur  = w_bit_sonu && (r_dur_sayac == r_dur_bit);
  assign w_hazir    = tx_en_i && !w_fifo_bos;
  // Pop and latch the frame settings on entry to BASLA, whether idle or back-to-back.
  assign w_yukle    = w_hazir && ((r_durum == c_BOSTA) || ((r_durum == c_DUR) && w_son_dur));

  assign w_kaydirma_sonraki = ((r_durum == c_VERI) && w_bit_sonu) ? (r_kaydirma >> 1) : r_kaydirma;

`ifdef UART_VERICI_PARITE_EN
  logic [1:0] r_parite_mod;
  logic       r_parite;
  logic       w_parite_sonraki;

  assign w_parite_var     = (r_parite_mod == c_PARITE_CIFT) || (r_parite_mod == c_PARITE_TEK);
  assign w_parite_sonraki = ((r_durum == c_VERI) && w_bit_sonu) ? (r_parite ^ r_kaydirma[0]) : r_parite;
  assign w_parite_cikis   = w_parite_sonraki ^ (r_parite_mod == c_PARITE_TEK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_parite_mod <= c_PARITE_YOK;
      r_parite     <= 1'b0;
    end else if (w_yukle) begin
      r_parite_mod <= parite_i;
      r_parite     <= 1'b0;
    end else begin
      r_parite     <= w_parite_sonraki;
    end
  end
`else
  logic w_unused_parite;
  assign w_unused_parite = ^parite_i;
  assign w_parite_var    = 1'b0;
  assign w_parite_cikis  = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum  <= c_BOSTA;
      r_tx     <= 1'b1;
      r_mesgul <= 1'b0;
    end else begin
      r_durum  <= w_sonraki;
      r_tx     <= w_tx_sonraki;
      r_mesgul <= w_mesgul_sonraki;
    end
  end

  always_comb begin
    w_sonraki = r_durum;
    case (r_durum)
      c_BOSTA:  if (w_hazir)    w_sonraki = c_BASLA;
      c_BASLA:  if (w_bit_sonu) w_sonraki = c_VERI;
      c_VERI:   if (w_son_veri) w_sonraki = w_parite_var ? c_PARITE : c_DUR;
      c_PARITE: if (w_bit_sonu) w_sonraki = c_DUR;
      c_DUR:    if (w_son_dur)  w_sonraki = w_hazir ? c_BASLA : c_BOSTA;
      default:                  w_sonraki = c_BOSTA;
    endcase
  end

  // Line level is decided from the upcoming state so the output can be a flop.
  always_comb begin
    w_tx_sonraki     = 1'b1;
    w_mesgul_sonraki = (w_sonraki != c_BOSTA);
    case (w_sonraki)
      c_BASLA:  w_tx_sonraki = 1'b0;
      c_VERI:   w_tx_sonraki = w_kaydirma_sonraki[0];
      c_PARITE: w_tx_sonraki = w_parite_cikis;
      default:  w_tx_sonraki = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_kaydirma   <= '0;
      r_baud_lim   <= '0;
      r_baud_sayac <= '0;
      r_bit_sayac  <= '0;
      r_veri_son   <= '0;
      r_dur_bit    <= 1'b0;
      r_dur_sayac  <= 1'b0;
    end else if (w_yukle) begin
      r_kaydirma   <= w_fifo_veri;
      r_baud_lim   <= baud_bolen_i;
      r_veri_son   <= veri_son_bit(veri_bit_i, VERI_MAX);
      r_dur_bit    <= dur_bit_i;
      r_baud_sayac <= '0;
      r_bit_sayac  <= '0;
      r_dur_sayac  <= 1'b0;
    end else if (r_durum != c_BOSTA) begin
      if (w_bit_sonu) begin
        r_baud_sayac <= '0;
        if (r_durum == c_VERI) begin
          r_kaydirma  <= w_kaydirma_sonraki;
          r_bit_sayac <= r_bit_sayac + 1'b1;
        end
        if (r_durum == c_DUR) begin
          r_dur_sayac <= r_dur_sayac + 1'b1;
        end
      end else begin
        r_baud_sayac <= r_baud_sayac + 1'b1;
      end
    end
  end

  assign tx_veri_o   = r_tx;
  assign tx_mesgul_o = r_mesgul;

endmodule

`default_nettype wire

// File: doc/uart_verici_param.md
UART_VERICI_PARAM -- requirements
Module: uart_verici_param

Interface
REQ-001 SHALL have parameter FIFO_DERINLIK, default 16, TX FIFO depth in entries (power of two, 2..256).
REQ-002 SHALL have parameter VERI_MAX, default 8, widest data word stored per entry (5..9).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port baud_bolen_i  input  16  bit period minus one, in clk_i cycles.
REQ-006 SHALL have port veri_bit_i  input  2  data bits per frame: 0=5, 1=6, 2=7, 3=VERI_MAX.
REQ-007 SHALL have port parite_i  input  2  parity mode: 0=none, 1=even, 2=odd, 3=none.
REQ-008 SHALL have port dur_bit_i  input  1  stop bits: 0=one, 1=two.
REQ-009 SHALL have port tx_en_i  input  1  frame start permitted while high.
REQ-010 SHALL have port tx_yaz_en_i  input  1  push tx_veri_i into the FIFO.
REQ-011 SHALL have port tx_veri_i  input  VERI_MAX  data word, LSB transmitted first.
REQ-012 SHALL have port tx_veri_o  output  1  serial line, idle high.
REQ-013 SHALL have ports tx_fifo_bos_o / tx_fifo_dolu_o  output  1  FIFO empty / full.
REQ-014 SHALL have port tx_doluluk_o  output  $clog2(FIFO_DERINLIK)+1  current FIFO occupancy.
REQ-015 SHALL have port tx_mesgul_o  output  1  high from frame start to end of final stop bit.
REQ-016 SHALL have port tx_tasma_o  output  1  one-cycle pulse when a push is dropped because the FIFO is full.

Function
REQ-017 SHALL implement states BOSTA, BASLA, VERI, PARITE, DUR; encodings in the package.
REQ-018 SHALL leave BOSTA for BASLA on the first cycle tx_en_i=1 and the FIFO is non-empty; the head word is popped in the same cycle.
REQ-019 SHALL latch baud_bolen_i, veri_bit_i, parite_i, dur_bit_i and the popped word on the BOSTA->BASLA transition; input changes mid-frame SHALL NOT affect the current frame.
REQ-020 SHALL hold every bit (start, data, parity, each stop) for exactly latched baud_bolen_i+1 cycles; a divisor of 0 gives 1-cycle bits.
REQ-021 SHALL drive tx_veri_o=0 in BASLA, data LSB first in VERI, parity in PARITE, 1 in DUR and BOSTA.
REQ-022 SHALL skip PARITE when parity mode is none; even parity bit = XOR of the sent data bits; odd = its inverse.
REQ-023 SHALL drive tx_veri_o from a register (no combinational path from any input).
REQ-024 SHALL, at the end of the last stop bit, enter BASLA directly (back-to-back frames, no idle bit) if tx_en_i=1 and the FIFO is non-empty, else enter BOSTA.
REQ-025 SHALL complete the current frame when tx_en_i falls mid-frame and start no further frame.
REQ-026 SHALL accept a push when full only if a pop occurs in the same cycle; otherwise drop the word and pulse tx_tasma_o.
REQ-027 SHALL keep occupancy unchanged on simultaneous push and pop when not full; pointers SHALL wrap modulo FIFO_DERINLIK.
REQ-028 SHALL ignore data bits above the configured width when veri_bit_i selects fewer than VERI_MAX bits.

Reset
REQ-029 SHALL, with rst_i high at a clock edge, set state BOSTA, tx_veri_o=1, FIFO empty (bos=1, dolu=0, doluluk=0), tx_mesgul_o=0, tx_tasma_o=0, counters zero.
REQ-030 SHALL abort any frame in progress on reset; tx_veri_o returns high on the cycle following the reset edge.

Configuration
REQ-031 SHALL compile the parity feature only when UART_VERICI_PARITE_EN is defined; without it parite_i is ignored, PARITE is never entered, and parity logic is absent.

Structure
REQ-032 SHALL place state encodings, veri_bit_i/parite_i code constants and the default FIFO depth in shared package uart_paket.
REQ-033 SHALL implement the FIFO as sub-module uart_tx_fifo (parameters DERINLIK, GENISLIK; first-word-fall-through; occupancy output).

Verification
REQ-034 SHALL check: divisor 3, 8N1, push 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, tx_mesgul_o high 40 cycles.
REQ-035 SHALL check (parity macro on): divisor 0, 7E2, push 0x55 -> start, 1010101, parity 0, two stop bits; 7O1 -> parity 1.
REQ-036 SHALL check: depth 4, push 6 words with tx_en_i=0 -> dolu after 4, two tx_tasma_o pulses, doluluk=4.
REQ-037 SHALL check: 3 words queued, tx_en_i=1 -> frames back-to-back, no idle cycle between last stop bit and next start bit.
REQ-038 SHALL check: rst_i asserted mid-VERI -> next cycle tx_veri_o=1, bos=1, mesgul=0; no residual frame after release.
REQ-039 SHALL check: change veri_bit_i 3->0 mid-frame -> current frame keeps 8 bits, next frame sends 5.
